button_capture: RTL and testbench

Debounces the eight game buttons and records the player's answer sequence for one round as 3-bit button indices. It sits between the board buttons and the round-compare logic in the game manager, downstream of pattern display. It arms when `enable` rises after the pattern has been shown. It fills 8/12/16 slots according to the selected level, then holds `end_signal` so the manager can compare slots against the generated pattern.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/button_debounce.sv | 44 ++++
 rtl/button_capture.sv | 105 ++++++++++
 tb/tb_button_capture.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: level encodings, slot geometry, capture FSM states
// and small helpers for decoding button vectors.
package game_pkg;

  localparam logic [2:0] LV1 = 3'b001;
  localparam logic [2:0] LV2 = 3'b010;
  localparam logic [2:0] LV3 = 3'b100;

  localparam int SLOT_W    = 3;
  localparam int MAX_SLOTS = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } cap_state_t;

  // Sequence length for a one-hot level; 0 marks an unusable level.
  function automatic logic [4:0] level_len(input logic [2:0] lv);
    case (lv)
      LV1:     return 5'd8;
      LV2:     return 5'd12;
      LV3:     return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic is_single(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [SLOT_W-1:0] button_index(input logic [7:0] v);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) idx = SLOT_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for the 8 game buttons.
// The output is the debounced vector as it stands after the current edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] botton,
  output logic [7:0] debounced
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] sync_p0;
  logic [7:0] sync_p1;
  logic [7:0] deb_q;
  logic [7:0] stable_cnt;
  logic       accept;

  // stable_cnt == CNT_MAX means sync_p1 has already held for DEBOUNCE_CYCLES
  // cycles, so the FSM may consume it on this very edge.
  assign accept    = (stable_cnt == CNT_MAX);
  assign debounced = accept ? sync_p1 : deb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      deb_q      <= '0;
      stable_cnt <= '0;
    end else begin
      // synchroniser stage p0 -> p1
      sync_p0 <= botton;
      sync_p1 <= sync_p0;
      // stability stage
      deb_q   <= debounced;
      if (sync_p0 != sync_p1)
        stable_cnt <= '0;
      else if (!accept)
        stable_cnt <= stable_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/button_capture.sv
// Captures one round of debounced button presses as 3-bit slot indices.
// Optional BUTTON_CAPTURE_ECHO_EN adds led_echo press feedback.
module button_capture
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  level,
  input  logic [7:0]  botton,
  output logic [47:0] trimmed_inp,
  output logic [4:0]  count,
  output logic        end_signal,
  output logic        multi_press
`ifdef BUTTON_CAPTURE_ECHO_EN
  ,
  output logic [7:0]  led_echo
`endif
);

  cap_state_t        state;
  logic [4:0]        len_q;
  logic [7:0]        deb;
  logic [SLOT_W-1:0] slots [MAX_SLOTS];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .botton    (botton),
    .debounced (deb)
  );

  always_comb begin
    trimmed_inp = '0;
    for (int i = 0; i < MAX_SLOTS; i++)
      trimmed_inp[SLOT_W*i +: SLOT_W] = slots[i];
  end

`ifdef BUTTON_CAPTURE_ECHO_EN
  assign led_echo = (state == WAIT_PRESS || state == WAIT_RELEASE) ? deb : 8'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      len_q       <= '0;
      count       <= '0;
      end_signal  <= 1'b0;
      multi_press <= 1'b0;
      for (int i = 0; i < MAX_SLOTS; i++) slots[i] <= '0;
    end else begin
      multi_press <= 1'b0;
      // Dropping enable aborts everything, including a press landing this edge.
      if (!enable) begin
        state      <= IDLE;
        count      <= '0;
        end_signal <= 1'b0;
        for (int i = 0; i < MAX_SLOTS; i++) slots[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (level_len(level) != 5'd0) begin
              len_q <= level_len(level);
              state <= ARMED;
            end
          end
          ARMED: begin
            if (deb == 8'd0) state <= WAIT_PRESS;
          end
          WAIT_PRESS: begin
            if (deb != 8'd0) begin
              if (is_single(deb)) begin
                slots[count[3:0]] <= button_index(deb);
                count             <= count + 5'd1;
                if (count + 5'd1 == len_q) begin
                  state      <= DONE;
                  end_signal <= 1'b1;
                end else begin
                  state <= WAIT_RELEASE;
                end
              end else begin
                multi_press <= 1'b1;
                state       <= WAIT_RELEASE;
              end
            end
          end
          WAIT_RELEASE: begin
            if (deb == 8'd0) state <= WAIT_PRESS;
          end
          DONE: begin
            end_signal <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture with a cycle-level behavioural model.
module tb_button_capture;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  level = 3'b001;
  logic [7:0]  botton = 8'd0;
  logic [47:0] trimmed_inp;
  logic [4:0]  count;
  logic        end_signal;
  logic        multi_press;
`ifdef BUTTON_CAPTURE_ECHO_EN
  logic [7:0]  led_echo;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mp_seen  = 0;
  int mp_base  = 0;

  button_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .level       (level),
    .botton      (botton),
    .trimmed_inp (trimmed_inp),
    .count       (count),
    .end_signal  (end_signal),
    .multi_press (multi_press)
`ifdef BUTTON_CAPTURE_ECHO_EN
    ,
    .led_echo    (led_echo)
`endif
  );

  always #5 clk = ~clk;

  // Model: raw-sample history, debounced value, round bookkeeping.
  logic [7:0] hist [8];
  logic [7:0] m_deb;
  bit         m_act, m_need_zero, m_done, m_mp;
  int         m_len;
  logic [2:0] m_slots [$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] model_pack();
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < m_slots.size(); i++) v[3*i +: 3] = m_slots[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 8'd0;
    m_deb = 8'd0;
    m_act = 0; m_need_zero = 0; m_done = 0; m_mp = 0; m_len = 0;
    m_slots.delete();
  endtask

  task automatic model_step();
    bit   steady;
    int   idx;
    // The synced value seen before edge n is the raw sample of edge n-2;
    // it is accepted once the last D such values agree.
    steady = 1;
    for (int i = 2; i <= D; i++) if (hist[i] !== hist[1]) steady = 0;
    if (steady) m_deb = hist[1];
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = botton;
    m_mp = 0;
    if (!enable) begin
      m_act = 0; m_done = 0; m_slots.delete();
    end else if (!m_act) begin
      if (level == 3'b001 || level == 3'b010 || level == 3'b100) begin
        m_act = 1;
        m_len = (level == 3'b001) ? 8 : (level == 3'b010) ? 12 : 16;
        m_need_zero = 1;
      end
    end else if (m_done) begin
      m_done = 1;
    end else if (m_need_zero) begin
      if (m_deb == 8'd0) m_need_zero = 0;
    end else if (m_deb != 8'd0) begin
      if ($countones(m_deb) == 1) begin
        idx = 0;
        for (int k = 0; k < 8; k++) if (m_deb[k]) idx = k;
        m_slots.push_back(3'(idx));
        if (m_slots.size() == m_len) m_done = 1;
      end else begin
        m_mp = 1;
      end
      m_need_zero = 1;
    end
  endtask

  initial begin : scoreboard
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) model_reset();
      else model_step();
      @(negedge clk);
      chk("count", {43'd0, count}, 48'(m_slots.size()));
      chk("end_signal", {47'd0, end_signal}, {47'd0, m_done});
      chk("multi_press", {47'd0, multi_press}, {47'd0, m_mp});
      chk("trimmed_inp", trimmed_inp, model_pack());
      if (multi_press) mp_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic press(input logic [7:0] b);
    botton = b;
    cyc(10);
    botton = 8'd0;
    cyc(10);
  endtask

  function automatic logic [7:0] btn(input int num);
    logic [7:0] one;
    one = 8'd1;
    return one << (num - 1);
  endfunction

  initial begin : stimulus
    int seq1 [8] = '{3, 1, 8, 2, 2, 5, 7, 4};

    // Reset state
    cyc(3);
    chk("rst_count", {43'd0, count}, 48'd0);
    chk("rst_slots", trimmed_inp, 48'd0);
    chk("rst_end", {47'd0, end_signal}, 48'd0);
    chk("rst_mp", {47'd0, multi_press}, 48'd0);
    rst = 1'b1;
    cyc(2);

    // Level 001, eight presses
    level = 3'b001;
    enable = 1'b1;
    cyc(3);
    foreach (seq1[i]) press(btn(seq1[i]));
    chk("t1_slots", trimmed_inp, 48'h0000_007A_13C2);
    chk("t1_model", model_pack(), 48'h0000_007A_13C2);
    chk("t1_count", {43'd0, count}, 48'd8);
    chk("t1_end", {47'd0, end_signal}, 48'd1);
    press(btn(1));
    chk("t1_ignored", {43'd0, count}, 48'd8);

    // Bounce on button 5
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(3);
    for (int i = 0; i < 10; i++) begin
      botton = (i % 2 == 0) ? 8'h10 : 8'h00;
      cyc(2);
    end
    botton = 8'd0;
    cyc(10);
    chk("bounce_count", {43'd0, count}, 48'd0);

    // Buttons 2 and 6 together, then 6 alone
    mp_base = mp_seen;
    press(8'h22);
    chk("multi_pulses", 48'(mp_seen - mp_base), 48'd1);
    chk("multi_count", {43'd0, count}, 48'd0);
    press(btn(6));
    chk("after_multi_slot", {45'd0, trimmed_inp[2:0]}, 48'd5);
    chk("after_multi_count", {43'd0, count}, 48'd1);

    // Button 1 held while enable rises
    enable = 1'b0;
    cyc(1);
    botton = btn(1);
    cyc(10);
    enable = 1'b1;
    cyc(15);
    chk("held_count", {43'd0, count}, 48'd0);
    botton = 8'd0;
    cyc(10);
    press(btn(1));
    chk("held_next_count", {43'd0, count}, 48'd1);
    chk("held_next_slots", trimmed_inp, 48'd0);

    // Level 100: abort after 5, then full 16 with level changed mid-round
    enable = 1'b0;
    cyc(1);
    level = 3'b100;
    enable = 1'b1;
    cyc(3);
    for (int i = 0; i < 5; i++) press(btn(i + 2));
    chk("pre_abort_count", {43'd0, count}, 48'd5);
    enable = 1'b0;
    cyc(1);
    chk("abort_count", {43'd0, count}, 48'd0);
    chk("abort_slots", trimmed_inp, 48'd0);
    chk("abort_end", {47'd0, end_signal}, 48'd0);
    enable = 1'b1;
    cyc(3);
    level = 3'b001;
    for (int i = 0; i < 16; i++) press(btn((i % 8) + 1));
    chk("lv3_count", {43'd0, count}, 48'd16);
    chk("lv3_end", {47'd0, end_signal}, 48'd1);
    chk("lv3_slots", trimmed_inp, 48'hFAC6_88FA_C688);

    // Invalid level 011
    enable = 1'b0;
    cyc(1);
    level = 3'b011;
    enable = 1'b1;
    mp_base = mp_seen;
    press(btn(4));
    press(8'h03);
    chk("inv_count", {43'd0, count}, 48'd0);
    chk("inv_end", {47'd0, end_signal}, 48'd0);
    chk("inv_slots", trimmed_inp, 48'd0);
    chk("inv_mp", 48'(mp_seen - mp_base), 48'd0);

    // enable falls on the edge that would write the slot
    enable = 1'b0;
    cyc(1);
    level = 3'b001;
    enable = 1'b1;
    cyc(3);
    botton = btn(3);
    cyc(D + 1);
    enable = 1'b0;
    cyc(1);
    chk("race_count", {43'd0, count}, 48'd0);
    chk("race_slots", trimmed_inp, 48'd0);
    botton = 8'd0;
    cyc(10);

    // Asynchronous reset mid-round
    enable = 1'b1;
    cyc(3);
    press(btn(8));
    press(btn(7));
    chk("pre_rst_count", {43'd0, count}, 48'd2);
    rst = 1'b0;
    #1;
    chk("async_rst_count", {43'd0, count}, 48'd0);
    chk("async_rst_slots", trimmed_inp, 48'd0);
    cyc(2);
    rst = 1'b1;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
